// File: rtl/img_mem_arbiter_if.sv
// Bus bundle between the image-memory arbiter, its three requesters
// (VGA scan-out, zoom engine, host port) and the single-port memory.
interface img_mem_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic              alg_req;
  logic              alg_we;
  logic [ADDR_W-1:0] alg_addr;
  logic [DATA_W-1:0] alg_wdata;
  logic              alg_gnt;
  logic [DATA_W-1:0] alg_rdata;
  logic              alg_rvalid;
  logic              alg_lock;
  logic              alg_locked;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  logic [15:0]       vga_drop_cnt;

  modport slave (
    input  vga_req, vga_addr,
    output vga_rdata, vga_rvalid,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    input  alg_req, alg_we, alg_addr, alg_wdata, alg_lock,
    output alg_gnt, alg_rdata, alg_rvalid, alg_locked,
    output mem_addr, mem_data, mem_wren,
    input  mem_q,
    output vga_drop_cnt
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_rdata, vga_rvalid,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    output alg_req, alg_we, alg_addr, alg_wdata, alg_lock,
    input  alg_gnt, alg_rdata, alg_rvalid, alg_locked,
    input  mem_addr, mem_data, mem_wren,
    output mem_q,
    input  vga_drop_cnt
  );
endinterface

// File: rtl/img_mem_arbiter.sv
// Image memory arbiter: VGA reads win every cycle, host and zoom engine
// share the rest round-robin, and the zoom engine can lock the memory.
//
//  state  | meaning
//  SHARED | normal arbitration, VGA first, host/alg round-robin
//  DRAIN  | lock requested; VGA still served, waiting for reads to return
//  LOCKED | alg owns memory; VGA reads answered with black, counted as drops
module img_mem_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input logic          clk_100,
  input logic          rst_n,
  img_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {SHARED, DRAIN, LOCKED} state_t;
  typedef enum logic [1:0] {OWN_VGA, OWN_HOST, OWN_ALG} own_t;

  state_t            state;
  logic              rr_alg;
  logic              alg_locked;

  logic              host_gnt, alg_gnt;
  logic              iss_vld, iss_we, vga_black;
  own_t              iss_own;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_data;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;

  // One entry per cycle of read latency; black entries ride alongside reads.
  logic [MEM_LAT:0]  tag_vld;
  logic [MEM_LAT:0]  tag_blk;
  own_t              tag_own [MEM_LAT+1];
  logic              pipe_empty;

  logic [DATA_W-1:0] vga_rdata, host_rdata, alg_rdata;
  logic              vga_rvalid, host_rvalid, alg_rvalid;
  logic [15:0]       drop_cnt;

  assign pipe_empty = ~|tag_vld;

  // Select this cycle's memory command and the combinational grants.
  always_comb begin
    host_gnt  = 1'b0;
    alg_gnt   = 1'b0;
    iss_vld   = 1'b0;
    iss_we    = 1'b0;
    iss_own   = OWN_VGA;
    iss_addr  = mem_addr;
    iss_data  = mem_data;
    vga_black = 1'b0;
    case (state)
      SHARED: begin
        if (bus.vga_req) begin
          iss_vld  = 1'b1;
          iss_addr = bus.vga_addr;
        end else if (bus.host_req && (!bus.alg_req || !rr_alg)) begin
          host_gnt = 1'b1;
        end else if (bus.alg_req) begin
          alg_gnt = 1'b1;
        end
      end
      DRAIN: begin
        if (bus.vga_req) begin
          iss_vld  = 1'b1;
          iss_addr = bus.vga_addr;
        end
      end
      LOCKED: begin
        vga_black = bus.vga_req;
        alg_gnt   = bus.alg_req;
      end
      default: ;
    endcase
    if (host_gnt) begin
      iss_vld  = 1'b1;
      iss_we   = bus.host_we;
      iss_own  = OWN_HOST;
      iss_addr = bus.host_addr;
      iss_data = bus.host_wdata;
    end else if (alg_gnt) begin
      iss_vld  = 1'b1;
      iss_we   = bus.alg_we;
      iss_own  = OWN_ALG;
      iss_addr = bus.alg_addr;
      iss_data = bus.alg_wdata;
    end
  end

  // Lock FSM and round-robin pointer; entering LOCKED waits for an empty pipe.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SHARED;
      alg_locked <= 1'b0;
      rr_alg     <= 1'b0;
    end else begin
      if (host_gnt)     rr_alg <= 1'b1;
      else if (alg_gnt) rr_alg <= 1'b0;
      case (state)
        SHARED: if (bus.alg_lock) state <= DRAIN;
        DRAIN: begin
          if (!bus.alg_lock) begin
            state <= SHARED;
          end else if (pipe_empty) begin
            state      <= LOCKED;
            alg_locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (!bus.alg_lock) begin
            state      <= SHARED;
            alg_locked <= 1'b0;
            rr_alg     <= 1'b0;
          end
        end
        default: state <= SHARED;
      endcase
    end
  end

  // Register the memory command; address and data hold when idle.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
    end else begin
      mem_addr <= iss_addr;
      mem_data <= iss_data;
      mem_wren <= iss_vld && iss_we;
    end
  end

  // Shift read tags and route returning mem_q to its owner.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld     <= '0;
      tag_blk     <= '0;
      for (int i = 0; i <= MEM_LAT; i++) tag_own[i] <= OWN_VGA;
      vga_rdata   <= '0;
      host_rdata  <= '0;
      alg_rdata   <= '0;
      vga_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      alg_rvalid  <= 1'b0;
    end else begin
      tag_vld[0] <= iss_vld && !iss_we;
      tag_blk[0] <= vga_black;
      tag_own[0] <= iss_own;
      for (int i = 1; i <= MEM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_blk[i] <= tag_blk[i-1];
        tag_own[i] <= tag_own[i-1];
      end
      vga_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      alg_rvalid  <= 1'b0;
      if (tag_vld[MEM_LAT]) begin
        case (tag_own[MEM_LAT])
          OWN_HOST: begin host_rvalid <= 1'b1; host_rdata <= bus.mem_q; end
          OWN_ALG:  begin alg_rvalid  <= 1'b1; alg_rdata  <= bus.mem_q; end
          default:  begin vga_rvalid  <= 1'b1; vga_rdata  <= bus.mem_q; end
        endcase
      end
      if (tag_blk[MEM_LAT]) begin
        vga_rvalid <= 1'b1;
        vga_rdata  <= '0;
      end
    end
  end

  // Count VGA reads answered with black while locked, saturating.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (vga_black && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.host_gnt     = host_gnt;
  assign bus.alg_gnt      = alg_gnt;
  assign bus.alg_locked   = alg_locked;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_data     = mem_data;
  assign bus.mem_wren     = mem_wren;
  assign bus.vga_rdata    = vga_rdata;
  assign bus.vga_rvalid   = vga_rvalid;
  assign bus.host_rdata   = host_rdata;
  assign bus.host_rvalid  = host_rvalid;
  assign bus.alg_rdata    = alg_rdata;
  assign bus.alg_rvalid   = alg_rvalid;
  assign bus.vga_drop_cnt = drop_cnt;

endmodule
